logit_argmax: RTL and testbench
===============================

LOGIT_ARGMAX -- requirements
Module: logit_argmax

Interface
REQ-001 SHALL have parameter VOCAB_SIZE, default 65: number of fp32 logits per frame, legal range 2..128.
REQ-002 SHALL have parameter TOKEN_W, default 7: width of the token index.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port s_axis_logit_tvalid, input, 1 bit: logit beat valid.
REQ-007 SHALL have port s_axis_logit_tready, output, 1 bit: block accepts a beat.
REQ-008 SHALL have port s_axis_logit_tdata, input, 32 bits: IEEE-754 single logit.
REQ-009 SHALL have port s_axis_logit_tlast, input, 1 bit: last logit of frame.
REQ-010 SHALL have port m_token, output, TOKEN_W bits: index of winning logit.
REQ-011 SHALL have port m_max_logit, output, 32 bits: winning logit value.
REQ-012 SHALL have port m_token_valid, output, 1 bit: result valid.
REQ-013 SHALL have port m_token_ready, input, 1 bit: consumer accepts result.
REQ-014 SHALL have port len_err, output, 1 bit: one-cycle pulse on frame length mismatch.

Function
REQ-015 SHALL implement states SCAN (tready=1) and HOLD (tready=0, m_token_valid=1).
REQ-016 SHALL accept a beat only when tvalid and tready are both 1, and SHALL keep an index counter idx of 0..VOCAB_SIZE-1.
REQ-017 SHALL load the first beat of a frame (idx=0) as best value and best index unconditionally.
REQ-018 For idx>0, SHALL replace the best only on strictly greater, so ties keep the lowest index.
REQ-019 SHALL compare in sign-magnitude order: -0 equals +0; +/-inf order normally.
REQ-020 A NaN logit SHALL never win a comparison against a non-NaN best; a NaN loaded at idx=0 SHALL be replaced by the first later non-NaN value.
REQ-021 SHALL end a frame on the accepted beat with tlast=1, or with idx=VOCAB_SIZE-1, whichever comes first.
REQ-022 SHALL pulse len_err for 1 cycle, coincident with entering HOLD, when the end condition has tlast and idx disagreeing (early tlast, or missing tlast at idx=VOCAB_SIZE-1).
REQ-023 SHALL register m_token and m_max_logit, and assert m_token_valid on the cycle after the final beat is accepted (latency 1).
REQ-024 SHALL hold m_token, m_max_logit and m_token_valid stable in HOLD until m_token_ready=1.
REQ-025 On handshake, SHALL return to SCAN with idx=0, and s_axis_logit_tready SHALL be 1 on the next cycle (no combinational ready path).
REQ-026 Throughput SHALL be 1 logit per cycle in SCAN, plus at least 1 cycle per frame for HOLD.

Reset
REQ-027 On rst_n=0, SHALL asynchronously set state=SCAN, idx=0, m_token=0, m_max_logit=0, m_token_valid=0 and len_err=0.
REQ-028 s_axis_logit_tready SHALL be 0 while rst_n=0 and 1 from the first clock after deassertion.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial frame and pending result, with no len_err pulse.

Structure
REQ-030 SHALL take VOCAB_SIZE, TOKEN_W and an fp32 typedef from shared package inference_pkg.
REQ-031 SHALL place the combinational comparison (a>b, NaN-aware, signed-zero-equal) in sub-module fp32_greater.

Verification
REQ-032 The bench SHALL send 65 logits all 0.0 except idx 17=3.5 and tlast at idx 64, then expect m_token=17, m_max_logit=0x40600000, len_err=0.
REQ-033 The bench SHALL send ties of 2.0 at idx 5 and 40, all others -1.0, then expect m_token=5.
REQ-034 The bench SHALL send idx 0=NaN (0x7FC00000), idx 3=-0.5, all others -inf, then expect m_token=3; separately, -0 at idx 0 and +0 at idx 1 SHALL give m_token=0.
REQ-035 The bench SHALL assert tlast at idx 9, then expect a len_err pulse and m_token equal to the argmax of idx 0..9; omitting tlast at idx 64 SHALL also pulse len_err.
REQ-036 The bench SHALL hold m_token_ready=0 for 10 cycles, then expect outputs stable and tready=0; after the handshake, tready=1 on the next cycle.
REQ-037 The bench SHALL pulse rst_n low at idx 30 and then send a full frame, expecting only the second frame's result.

Source files
------------

// File: rtl/inference_pkg.sv
// Shared types and defaults for the token-selection datapath.
package inference_pkg;

    localparam int DEF_VOCAB_SIZE = 65;
    localparam int DEF_TOKEN_W    = 7;

    // IEEE-754 single precision, field view.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fp32_t;

    // Both quiet and signalling NaNs: all-ones exponent with a non-zero mantissa.
    function automatic logic fp32_is_nan(input fp32_t v);
        return (v.exponent == 8'hFF) && (v.mantissa != '0);
    endfunction

    // True for both +0 and -0.
    function automatic logic fp32_is_zero(input fp32_t v);
        return (v.exponent == 8'h00) && (v.mantissa == '0);
    endfunction

endpackage

// File: rtl/fp32_greater.sv
// Combinational strict a > b on fp32 values.
// NaN never wins against a number, and any number beats a NaN. This lets a NaN
// sitting in the best register be displaced by the first real value.
// The two zeros compare equal. Infinities and denormals fall out of the
// sign-magnitude ordering with no special handling.
module fp32_greater
    import inference_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output logic  a_gt_b
);

    logic        a_nan;
    logic        b_nan;
    logic        both_zero;
    logic [30:0] a_mag;
    logic [30:0] b_mag;

    assign a_nan     = fp32_is_nan(a);
    assign b_nan     = fp32_is_nan(b);
    assign both_zero = fp32_is_zero(a) && fp32_is_zero(b);
    assign a_mag     = {a.exponent, a.mantissa};
    assign b_mag     = {b.exponent, b.mantissa};

    // Sign-magnitude ordering with the NaN and signed-zero cases decided first.
    always_comb begin
        a_gt_b = 1'b0;
        if (a_nan) begin
            a_gt_b = 1'b0;
        end else if (b_nan) begin
            a_gt_b = 1'b1;
        end else if (both_zero) begin
            a_gt_b = 1'b0;
        end else if (a.sign != b.sign) begin
            a_gt_b = b.sign;
        end else if (!a.sign) begin
            a_gt_b = (a_mag > b_mag);
        end else begin
            a_gt_b = (a_mag < b_mag);
        end
    end

endmodule

// File: rtl/logit_argmax.sv
// Streaming argmax over one frame of fp32 logits.
// The block scans one logit per cycle. It then holds the winning index and
// value until the consumer takes them.
//
// state | meaning
// ------+-----------------------------------------------------------------
// SCAN  | accepting logits (tready=1 once out of reset), tracking the best
// HOLD  | result presented (m_token_valid=1, tready=0) until m_token_ready
module logit_argmax
    import inference_pkg::*;
#(
    parameter int VOCAB_SIZE = DEF_VOCAB_SIZE,
    parameter int TOKEN_W    = DEF_TOKEN_W
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               s_axis_logit_tvalid,
    output logic               s_axis_logit_tready,
    input  logic [31:0]        s_axis_logit_tdata,
    input  logic               s_axis_logit_tlast,

    output logic [TOKEN_W-1:0] m_token,
    output logic [31:0]        m_max_logit,
    output logic               m_token_valid,
    input  logic               m_token_ready,

    output logic               len_err
);

    localparam logic [0:0] ST_SCAN = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [TOKEN_W-1:0] LAST_IDX = TOKEN_W'(VOCAB_SIZE - 1);

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic               tready_r;

    logic [TOKEN_W-1:0] idx;
    fp32_t              best_val;
    logic [TOKEN_W-1:0] best_idx;

    fp32_t              beat;
    logic               accept;
    logic               at_last_idx;
    logic               frame_end;
    logic               beat_gt_best;
    logic               take_beat;
    fp32_t              best_val_next;
    logic [TOKEN_W-1:0] best_idx_next;

    assign beat                = fp32_t'(s_axis_logit_tdata);
    assign s_axis_logit_tready = tready_r;

    // Ready comes from a flop, so it never depends combinationally on m_token_ready.
    assign accept      = s_axis_logit_tvalid && tready_r && (state == ST_SCAN);
    assign at_last_idx = (idx == LAST_IDX);
    assign frame_end   = accept && (s_axis_logit_tlast || at_last_idx);

    fp32_greater u_cmp (
        .a      (beat),
        .b      (best_val),
        .a_gt_b (beat_gt_best)
    );

    // Strictly-greater replacement keeps the lowest index on ties.
    // The first beat always loads, whatever its value.
    assign take_beat     = (idx == '0) || beat_gt_best;
    assign best_val_next = take_beat ? beat : best_val;
    assign best_idx_next = take_beat ? idx  : best_idx;

    // Next-state decode for the SCAN/HOLD sequencer.
    always_comb begin
        state_next = state;
        case (state)
            ST_SCAN: if (frame_end)     state_next = ST_HOLD;
            ST_HOLD: if (m_token_ready) state_next = ST_SCAN;
            default:                    state_next = ST_SCAN;
        endcase
    end

    // State register. Ready is registered from the next state so it rises the
    // cycle after a handshake and stays low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SCAN;
            tready_r <= 1'b0;
        end else begin
            state    <= state_next;
            tready_r <= (state_next == ST_SCAN);
        end
    end

    // Running index and best-so-far tracking over the accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else if (accept) begin
            best_val <= best_val_next;
            best_idx <= best_idx_next;
            if (frame_end) begin
                idx <= '0;
            end else begin
                idx <= idx + TOKEN_W'(1);
            end
        end
    end

    // Result registers. They load on the final beat and hold through HOLD.
    // len_err flags disagreement between tlast and the expected frame length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_token       <= '0;
            m_max_logit   <= '0;
            m_token_valid <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (frame_end) begin
                m_token       <= best_idx_next;
                m_max_logit   <= best_val_next;
                m_token_valid <= 1'b1;
                len_err       <= s_axis_logit_tlast ^ at_last_idx;
            end else if ((state == ST_HOLD) && m_token_ready) begin
                m_token_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logit_argmax.sv
// Directed bench for logit_argmax with hand-computed expectations.
module tb_logit_argmax;

    localparam int V  = 65;
    localparam int TW = 7;

    localparam logic [31:0] F_ZERO  = 32'h0000_0000;
    localparam logic [31:0] F_NZERO = 32'h8000_0000;
    localparam logic [31:0] F_ONE   = 32'h3F80_0000;
    localparam logic [31:0] F_M1    = 32'hBF80_0000;
    localparam logic [31:0] F_TWO   = 32'h4000_0000;
    localparam logic [31:0] F_3P5   = 32'h4060_0000;
    localparam logic [31:0] F_5     = 32'h40A0_0000;
    localparam logic [31:0] F_7     = 32'h40E0_0000;
    localparam logic [31:0] F_50    = 32'h4248_0000;
    localparam logic [31:0] F_MHALF = 32'hBF00_0000;
    localparam logic [31:0] F_NINF  = 32'hFF80_0000;
    localparam logic [31:0] F_NAN   = 32'h7FC0_0000;
    localparam logic [31:0] F_BIG   = 32'h7F00_0000;

    logic          clk;
    logic          rst_n;
    logic          tvalid;
    logic          tready;
    logic [31:0]   tdata;
    logic          tlast;
    logic [TW-1:0] m_token;
    logic [31:0]   m_max_logit;
    logic          m_token_valid;
    logic          m_token_ready;
    logic          len_err;

    int            tests;
    int            fails;
    logic [31:0]   frm [V];
    logic [TW-1:0] tok_snap;
    logic [31:0]   max_snap;

    logit_argmax #(.VOCAB_SIZE(V), .TOKEN_W(TW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .s_axis_logit_tvalid (tvalid),
        .s_axis_logit_tready (tready),
        .s_axis_logit_tdata  (tdata),
        .s_axis_logit_tlast  (tlast),
        .m_token             (m_token),
        .m_max_logit         (m_max_logit),
        .m_token_valid       (m_token_valid),
        .m_token_ready       (m_token_ready),
        .len_err             (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < V; i++) frm[i] = v;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int waited;
        waited = 0;
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        while (!tready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!tready) check("tready_timeout", 32'(tready), 32'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // Sends beats 0..n-1, with tlast on beat last_at (-1 means never).
    task automatic send_frame(input int n, input int last_at);
        for (int i = 0; i < n; i++) send_beat(frm[i], (i == last_at));
    endtask

    task automatic expect_result(input string tag, input int tok, input logic [31:0] mx, input logic le);
        check({tag, "_valid"},  32'(m_token_valid), 32'd1);
        check({tag, "_token"},  32'(m_token),       32'(tok));
        check({tag, "_max"},    m_max_logit,        mx);
        check({tag, "_lenerr"}, 32'(len_err),       32'(le));
        check({tag, "_tready"}, 32'(tready),        32'd0);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        m_token_ready = 1'b1;
        @(posedge clk);
        #1;
        m_token_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(m_token_valid), 32'd0);
        check({tag, "_tready_back"}, 32'(tready), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        tvalid = 1'b0;
        tdata = '0;
        tlast = 1'b0;
        m_token_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_valid", 32'(m_token_valid), 32'd0);
        check("rst_token", 32'(m_token), 32'd0);
        check("rst_max", m_max_logit, 32'd0);
        check("rst_lenerr", 32'(len_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_tready", 32'(tready), 32'd1);

        // Single peak of 3.5 at idx 17, then hold ready low for 10 cycles
        fill(F_ZERO);
        frm[17] = F_3P5;
        send_frame(V, V - 1);
        expect_result("peak", 17, F_3P5, 1'b0);
        tok_snap = m_token;
        max_snap = m_max_logit;
        tvalid = 1'b1;
        tdata  = F_BIG;
        tlast  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid",  32'(m_token_valid), 32'd1);
            check("hold_token",  32'(m_token), 32'(tok_snap));
            check("hold_max",    m_max_logit, max_snap);
            check("hold_tready", 32'(tready), 32'd0);
            check("hold_lenerr", 32'(len_err), 32'd0);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        consume("peak");

        // Ties of 2.0 at idx 5 and 40: the lower index wins
        fill(F_M1);
        frm[5]  = F_TWO;
        frm[40] = F_TWO;
        send_frame(V, V - 1);
        expect_result("tie", 5, F_TWO, 1'b0);
        consume("tie");

        // NaN at idx 0 is displaced, and -0.5 at idx 3 beats -inf
        fill(F_NINF);
        frm[0] = F_NAN;
        frm[3] = F_MHALF;
        send_frame(V, V - 1);
        expect_result("nan", 3, F_MHALF, 1'b0);
        consume("nan");

        // -0 at idx 0 and +0 at idx 1 compare equal, so idx 0 keeps the win
        fill(F_M1);
        frm[0] = F_NZERO;
        frm[1] = F_ZERO;
        send_frame(V, V - 1);
        expect_result("szero", 0, F_NZERO, 1'b0);
        consume("szero");

        // Early tlast at idx 9: argmax of idx 0..9 is idx 6; a later, larger value is never sent
        fill(F_ONE);
        frm[6]  = F_5;
        frm[20] = F_50;
        send_frame(10, 9);
        expect_result("early", 6, F_5, 1'b1);
        @(posedge clk);
        #1;
        check("early_lenerr_1cyc", 32'(len_err), 32'd0);
        check("early_still_valid", 32'(m_token_valid), 32'd1);
        consume("early");

        // Missing tlast: frame closes at idx 64 with a length error
        fill(F_ZERO);
        frm[64] = F_ONE;
        send_frame(V, -1);
        expect_result("notlast", 64, F_ONE, 1'b1);
        consume("notlast");

        // Reset at idx 30 drops the partial frame; only the next frame reports
        fill(F_ONE);
        frm[10] = F_50;
        send_frame(30, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tready", 32'(tready), 32'd0);
        check("midrst_valid", 32'(m_token_valid), 32'd0);
        check("midrst_lenerr", 32'(len_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tready_back", 32'(tready), 32'd1);
        check("midrst_no_result", 32'(m_token_valid), 32'd0);
        fill(F_ONE);
        frm[44] = F_7;
        send_frame(V, V - 1);
        expect_result("after_rst", 44, F_7, 1'b0);
        consume("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
